// File: rtl/etc_ex.sv
// -----------------------------------------------------------------------------
// etc_ex : execute stage of the extended tensor core (ETC)
//
// Computes one 4x4 by 4x4 matrix operation per clock over a selectable
// semiring:  out[i][j] = REDUCE_k( COMBINE(inA[i][k], inB[k][j]) ), k = 0..3.
// The result tile is registered, so the latency is one clock. A new op can
// be issued every cycle. There is no handshake and no stall.
//
// Ports
//    clk    in   1                    clock, all state on posedge
//    rst_n  in   1                    asynchronous active-low reset
//    op     in   4                    semiring select (see OP_* below)
//    inA    in   [3:0][3:0][W-1:0]    matrix A, inA[row][col]
//    inB    in   [3:0][3:0][W-1:0]    matrix B, inB[row][col]
//    out    out  [3:0][3:0][W-1:0]    registered result, out[row][col]
//
// Configuration macro
//    ETC_SAT_EN  when defined, every add and multiply saturates at 2^W-1.
//                Saturation applies to each term and to each reduction step.
//                When it is undefined, arithmetic wraps modulo 2^W.
//                Compare operations are the same in both builds.
// -----------------------------------------------------------------------------
module etc_ex #(
   parameter int W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [3:0]                 op,
   input  logic [3:0][3:0][W-1:0]     inA,
   input  logic [3:0][3:0][W-1:0]     inB,
   output logic [3:0][3:0][W-1:0]     out
);

   localparam logic [3:0] OP_PLUS_MUL  = 4'b0000;
   localparam logic [3:0] OP_MIN_PLUS  = 4'b0001;
   localparam logic [3:0] OP_MAX_PLUS  = 4'b0010;
   localparam logic [3:0] OP_MIN_MUL   = 4'b0011;
   localparam logic [3:0] OP_MAX_MUL   = 4'b0100;
   localparam logic [3:0] OP_MIN_MAX   = 4'b0101;
   localparam logic [3:0] OP_MAX_MIN   = 4'b0110;
   localparam logic [3:0] OP_OR_AND    = 4'b0111;
   localparam logic [3:0] OP_PLUS_NORM = 4'b1000;

   logic [3:0][3:0][W-1:0] next_out;

   // W-bit add. The sum either wraps or clamps at all-ones, depending on
   // the build. Terms are unsigned, so clamping each step gives the same
   // result in any reduction order.
   function automatic logic [W-1:0] add_w(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ETC_SAT_EN
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      add_w = s[W] ? {W{1'b1}} : s[W-1:0];
`else
      add_w = a + b;
`endif
   endfunction

   // W-bit multiply with the same wrap/clamp choice as add_w.
   function automatic logic [W-1:0] mul_w(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ETC_SAT_EN
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      mul_w = (|p[2*W-1:W]) ? {W{1'b1}} : p[W-1:0];
`else
      mul_w = a * b;
`endif
   endfunction

   // Produces one output element: the four COMBINE terms are formed first,
   // then they are folded with REDUCE. The fold starts from term 0, so no
   // identity or infinity value is needed. Reserved op codes leave every
   // term and the accumulator at zero.
   function automatic logic [W-1:0] calc_elem(
      input logic [3:0]                 sel,
      input logic [3:0][W-1:0]          a_row,
      input logic [3:0][3:0][W-1:0]     b_mat,
      input int                         col
   );
      logic [3:0][W-1:0] term;
      logic [W-1:0]      a;
      logic [W-1:0]      b;
      logic [W-1:0]      diff;
      logic [W-1:0]      acc;
      term = '0;
      for (int k = 0; k < 4; k++) begin
         a = a_row[k];
         b = b_mat[k][col];
         diff = (a >= b) ? (a - b) : (b - a);
         case (sel)
            OP_PLUS_MUL, OP_MIN_MUL, OP_MAX_MUL: term[k] = mul_w(a, b);
            OP_MIN_PLUS, OP_MAX_PLUS:            term[k] = add_w(a, b);
            OP_MIN_MAX:                          term[k] = (a > b) ? a : b;
            OP_MAX_MIN:                          term[k] = (a < b) ? a : b;
            OP_OR_AND:                           term[k] = {{(W-1){1'b0}}, ((a != '0) && (b != '0))};
            OP_PLUS_NORM:                        term[k] = mul_w(diff, diff);
            default:                             term[k] = '0;
         endcase
      end
      acc = term[0];
      for (int k = 1; k < 4; k++) begin
         case (sel)
            OP_PLUS_MUL, OP_PLUS_NORM:           acc = add_w(acc, term[k]);
            OP_MIN_PLUS, OP_MIN_MUL, OP_MIN_MAX: acc = (term[k] < acc) ? term[k] : acc;
            OP_MAX_PLUS, OP_MAX_MUL, OP_MAX_MIN: acc = (term[k] > acc) ? term[k] : acc;
            OP_OR_AND:                           acc = acc | term[k];
            default:                             acc = '0;
         endcase
      end
      calc_elem = acc;
   endfunction

   // The whole tile is computed combinationally from the current operands.
   // Each of the 16 elements uses its own row of A and column of B.
   always_comb begin
      next_out = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            next_out[i][j] = calc_elem(op, inA[i], inB, j);
         end
      end
   end

   // Result register. Asserting reset clears the tile at once and discards
   // any result in flight. The first edge after release computes normally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else begin
         out <= next_out;
      end
   end

endmodule

// File: tb/tb_etc_ex.sv
// -----------------------------------------------------------------------------
// tb_etc_ex : directed self-checking bench for etc_ex
//
// Uses a small operand set with hand-computed results for every semiring.
// It also covers reset behaviour, reserved op codes, overflow and
// back-to-back op changes. With ETC_SAT_EN defined, the overflow
// expectations switch to the saturating values.
// -----------------------------------------------------------------------------
module tb_etc_ex;

   localparam int W = 16;

   logic                    clk;
   logic                    rst_n;
   logic [3:0]              op;
   logic [3:0][3:0][W-1:0]  in_a;
   logic [3:0][3:0][W-1:0]  in_b;
   logic [3:0][3:0][W-1:0]  out;

   int error_count;
   int check_count;

   logic [3:0][3:0][W-1:0]  exp_plus_mul;

   etc_ex #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .op    (op),
      .inA   (in_a),
      .inB   (in_b),
      .out   (out)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it if the values differ.
   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Drives op on the falling edge and lets one rising edge capture it.
   // Sampling happens 1 ns after that edge.
   task automatic applyStimulus(input logic [3:0] op_v);
      @(negedge clk);
      op = op_v;
      @(posedge clk);
      #1;
   endtask

   // Loads the reference operand set. All unlisted elements are zero.
   task automatic loadOperands();
      in_a = '0;
      in_b = '0;
      in_a[0][0] = 16'd1; in_a[0][1] = 16'd1; in_a[0][2] = 16'd5; in_a[0][3] = 16'd2;
      in_a[1][0] = 16'd3;
      in_a[2][0] = 16'd1;
      in_b[0][0] = 16'd1; in_b[1][0] = 16'd1; in_b[2][0] = 16'd6; in_b[3][0] = 16'd2;
      in_b[0][1] = 16'd3;
      in_b[0][2] = 16'd8;
   endtask

   initial begin
      error_count = 0;
      check_count = 0;
      rst_n = 1'b0;
      op = 4'b0000;
      in_a = '0;
      in_b = '0;

      exp_plus_mul = '0;
      exp_plus_mul[0][0] = 16'd36; exp_plus_mul[0][1] = 16'd3; exp_plus_mul[0][2] = 16'd8;
      exp_plus_mul[1][0] = 16'd3;  exp_plus_mul[1][1] = 16'd9; exp_plus_mul[1][2] = 16'd24;
      exp_plus_mul[2][0] = 16'd1;  exp_plus_mul[2][1] = 16'd3; exp_plus_mul[2][2] = 16'd8;

      #1;
      checkOutput("reset_clear", 256'(out), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      loadOperands();

      // plus/mul over the full tile
      applyStimulus(4'b0000);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("plus_mul[%0d][%0d]", i, j), 256'(out[i][j]), 256'(exp_plus_mul[i][j]));
         end
      end

      applyStimulus(4'b0010);
      checkOutput("max_plus[0][0]", 256'(out[0][0]), 256'd11);
      checkOutput("max_plus[1][1]", 256'(out[1][1]), 256'd6);
      checkOutput("max_plus[3][3]", 256'(out[3][3]), 256'd0);

      applyStimulus(4'b0001);
      checkOutput("min_plus[0][0]", 256'(out[0][0]), 256'd2);
      checkOutput("min_plus[0][1]", 256'(out[0][1]), 256'd1);
      checkOutput("min_plus[3][3]", 256'(out[3][3]), 256'd0);

      applyStimulus(4'b0011);
      checkOutput("min_mul[0][0]", 256'(out[0][0]), 256'd1);
      applyStimulus(4'b0100);
      checkOutput("max_mul[0][0]", 256'(out[0][0]), 256'd30);
      applyStimulus(4'b0101);
      checkOutput("min_max[0][0]", 256'(out[0][0]), 256'd1);
      applyStimulus(4'b0110);
      checkOutput("max_min[0][0]", 256'(out[0][0]), 256'd5);

      applyStimulus(4'b0111);
      checkOutput("or_and[0][0]", 256'(out[0][0]), 256'd1);
      checkOutput("or_and[1][1]", 256'(out[1][1]), 256'd1);
      checkOutput("or_and[3][3]", 256'(out[3][3]), 256'd0);

      applyStimulus(4'b1000);
      checkOutput("norm[0][0]", 256'(out[0][0]), 256'd1);
      checkOutput("norm[0][1]", 256'(out[0][1]), 256'd34);
      checkOutput("norm[3][3]", 256'(out[3][3]), 256'd0);

      // Asynchronous reset mid-stream: the tile must clear between clock edges.
      applyStimulus(4'b0000);
      checkOutput("pre_reset[0][0]", 256'(out[0][0]), 256'd36);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 256'(out), 256'd0);
      @(posedge clk);
      #1;
      checkOutput("reset_held", 256'(out), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_release[0][0]", 256'(out[0][0]), 256'd36);

      applyStimulus(4'b1111);
      checkOutput("reserved_1111", 256'(out), 256'd0);
      applyStimulus(4'b1001);
      checkOutput("reserved_1001", 256'(out), 256'd0);

      // Back-to-back op changes, each followed one edge later.
      applyStimulus(4'b0000);
      checkOutput("seq_plus_mul", 256'(out[0][0]), 256'd36);
      applyStimulus(4'b0010);
      checkOutput("seq_max_plus", 256'(out[0][0]), 256'd11);
      applyStimulus(4'b0001);
      checkOutput("seq_min_plus", 256'(out[0][0]), 256'd2);

      // Overflow: 300*300 wraps to 24464, or saturates to 65535.
      @(negedge clk);
      in_a = '0;
      in_b = '0;
      in_a[0][0] = 16'd300;
      in_b[0][0] = 16'd300;
      applyStimulus(4'b0000);
`ifdef ETC_SAT_EN
      checkOutput("ovf_mul", 256'(out[0][0]), 256'd65535);
`else
      checkOutput("ovf_mul", 256'(out[0][0]), 256'd24464);
`endif

      // Overflow on add: 65535+1 gives 0 (wrap) or 65535 (saturate).
      @(negedge clk);
      in_a[0][0] = 16'hFFFF;
      in_b[0][0] = 16'd1;
      applyStimulus(4'b0010);
`ifdef ETC_SAT_EN
      checkOutput("ovf_add", 256'(out[0][0]), 256'd65535);
`else
      checkOutput("ovf_add", 256'(out[0][0]), 256'd0);
`endif

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
